// File: rtl/polymul_pkg.sv
// Shared defaults and types for the sequential schoolbook polynomial multiplier.
package polymul_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 2;
  localparam int AW_DEF = 2 * CW_DEF + $clog2(N_DEF);

  // IDLE waits for start, MAC runs one B coefficient per cycle, DONE pulses done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [CW_DEF-1:0] coef_t;
  typedef logic [AW_DEF-1:0] acc_t;

endpackage

// File: rtl/polymul_seq_coef_shift_reg.sv
// Bit-plane coefficient shift register: holds operand B and presents b_k at the
// head, advancing one coefficient per shift.
module coef_shift_reg #(
  parameter int N  = polymul_pkg::N_DEF,
  parameter int CW = polymul_pkg::CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [N-1:0]  i_data0,
  input  logic [N-1:0]  i_data1,
  output logic [CW-1:0] o_head
);

  logic [N-1:0] r_plane0;
  logic [N-1:0] r_plane1;

  // Load has priority; a shift moves every plane down by one coefficient position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_plane0 <= '0;
      r_plane1 <= '0;
    end else if (i_load) begin
      r_plane0 <= i_data0;
      r_plane1 <= i_data1;
    end else if (i_shift) begin
      r_plane0 <= {1'b0, r_plane0[N-1:1]};
      r_plane1 <= {1'b0, r_plane1[N-1:1]};
    end
  end

  assign o_head = CW'({r_plane1[0], r_plane0[0]});

endmodule

// File: rtl/polymul_seq.sv
// Sequencer and accumulator for one schoolbook polynomial multiplication.
// Handshake: start is accepted only in IDLE (busy=0, done=0); busy is high for
// the N MAC cycles, done pulses for one cycle afterwards, and res/res_valid hold
// until the next accepted start clears them.
module polymul_seq
  import polymul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N-1:0]          a_data0,
  input  logic [N-1:0]          a_data1,
  input  logic [N-1:0]          b_data0,
  input  logic [N-1:0]          b_data1,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  output logic [(2*N-1)*(2*CW+$clog2(N))-1:0] res,
  output state_t                o_dbg_state
);

  localparam int AW   = 2 * CW + $clog2(N);
  localparam int NC   = 2 * N - 1;
  localparam int CNTW = $clog2(N);
  localparam int IDXW = $clog2(NC);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [CNTW-1:0]   r_cnt;
  logic [CW-1:0]     r_a [N];
  logic [AW-1:0]     r_acc [NC];

  logic [CW-1:0]     w_a [N];
  logic [CW-1:0]     w_head;
  logic [2*CW-1:0]   w_prod [N];
  logic [AW-1:0]     w_acc_next [NC];
  logic              w_accept;
  logic              w_shift;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_shift  = (r_state == ST_MAC);

  coef_shift_reg #(.N(N), .CW(CW)) u_bsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data0 (b_data0),
    .i_data1 (b_data1),
    .o_head  (w_head)
  );

  // Assemble A coefficients from the bit-planes: a_i = {plane1[i], plane0[i]}.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a[i] = CW'({a_data1[i], a_data0[i]});
    end
  end

  // Partial products a_j * b_k, full 2CW-bit unsigned.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_prod[j] = (2*CW)'(r_a[j]) * (2*CW)'(w_head);
    end
  end

  // Next accumulator bank for the current step: c_{k+j} += a_j * b_k.
  always_comb begin
    logic [IDXW-1:0] w_idx;
    w_idx = '0;
    for (int m = 0; m < NC; m++) begin
      w_acc_next[m] = r_acc[m];
    end
    for (int j = 0; j < N; j++) begin
      w_idx = IDXW'(r_cnt) + IDXW'(j);
      w_acc_next[w_idx] = w_acc_next[w_idx] + AW'(w_prod[j]);
    end
  end

  // Control FSM with registered busy/done/res_valid and the accumulator bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < N; i++) r_a[i] <= '0;
      for (int m = 0; m < NC; m++) r_acc[m] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= w_a;
            for (int m = 0; m < NC; m++) r_acc[m] <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pack the accumulator bank: c_k at res[k*AW +: AW].
  always_comb begin
    res = '0;
    for (int k = 0; k < NC; k++) begin
      res[k*AW +: AW] = r_acc[k];
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign res_valid   = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_polymul_seq.sv
// Directed bench for polymul_seq (N=4, CW=2, AW=6).
module tb_polymul_seq;
  import polymul_pkg::*;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int RW = (2*N-1)*AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [N-1:0]  a_data0, a_data1, b_data0, b_data1;
  logic          busy, done, res_valid;
  logic [RW-1:0] res;
  state_t        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  polymul_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_data0     (a_data0),
    .a_data1     (a_data1),
    .b_data0     (b_data0),
    .b_data1     (b_data1),
    .busy        (busy),
    .done        (done),
    .res_valid   (res_valid),
    .res         (res),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are examined 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] pack7(input int c0, c1, c2, c3, c4, c5, c6);
    logic [RW-1:0] v;
    v = '0;
    v[0*AW +: AW] = AW'(c0);
    v[1*AW +: AW] = AW'(c1);
    v[2*AW +: AW] = AW'(c2);
    v[3*AW +: AW] = AW'(c3);
    v[4*AW +: AW] = AW'(c4);
    v[5*AW +: AW] = AW'(c5);
    v[6*AW +: AW] = AW'(c6);
    return v;
  endfunction

  task automatic set_ops(input logic [3:0] a1, a0, b1, b0);
    a_data1 = a1; a_data0 = a0; b_data1 = b1; b_data0 = b0;
  endtask

  // One full operation from cycle 0 (start driven) through cycle N+2.
  task automatic run_op(input string tag, input logic [3:0] a1, a0, b1, b0,
                        input logic [RW-1:0] exp_res);
    set_ops(a1, a0, b1, b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      tick();
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_res"}, 64'(res), 64'(exp_res));
    tick();
    check({tag, "_done_once"}, 64'(done), 64'd0);
    check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_hold_res"}, 64'(res), 64'(exp_res));
  endtask

  logic [RW-1:0] exp_ramp, exp_max;
  int done_cnt;
  int done_c1, done_c2;

  initial begin
    exp_ramp = pack7(0, 1, 3, 6, 6, 5, 3);
    exp_max  = pack7(9, 18, 27, 36, 27, 18, 9);
    start = 1'b0;
    set_ops(4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // 1: ramp times ones
    run_op("ramp", 4'b1100, 4'b1010, 4'b0000, 4'b1111, exp_ramp);
    // 2: maximum values
    run_op("max", 4'b1111, 4'b1111, 4'b1111, 4'b1111, exp_max);
    // 3: zero B operand
    run_op("zero", 4'b0110, 4'b1011, 4'b0000, 4'b0000, '0);

    // 4: start during busy is ignored
    set_ops(4'b1100, 4'b1010, 4'b0000, 4'b1111);
    start = 1'b1;
    tick();                       // cycle 1
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        start = 1'b1;
        set_ops(4'b1111, 4'b1111, 4'b1111, 4'b1111);
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      if (c == 5) check("busy_start_res", 64'(res), 64'(exp_ramp));
      tick();
    end
    check("busy_start_ndone", 64'(done_cnt), 64'd1);
    check("busy_start_hold", 64'(res), 64'(exp_ramp));

    // 5: reset in cycle 3 of a max-value operation
    set_ops(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    start = 1'b1;
    tick();                       // cycle 1
    start = 1'b0;
    tick();                       // cycle 2
    tick();                       // cycle 3
    reset = 1'b1;
    tick();                       // cycle 4
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_res", 64'(res), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_cnt++;
      tick();
    end
    check("mid_rst_nodone", 64'(done_cnt), 64'd0);
    run_op("after_rst", 4'b1100, 4'b1010, 4'b0000, 4'b1111, exp_ramp);

    // 6: back-to-back with start held high
    set_ops(4'b1100, 4'b1010, 4'b0000, 4'b1111);
    start = 1'b1;
    tick();                       // cycle 1
    set_ops(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    done_c1 = -1;
    done_c2 = -1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 7) start = 1'b0;
      if (done && done_c1 < 0) done_c1 = c;
      else if (done) done_c2 = c;
      check($sformatf("b2b_valid_c%0d", c), 64'(res_valid),
            64'((c == 5 || c == 6 || c == 11) ? 1 : 0));
      if (c == 5)  check("b2b_res1", 64'(res), 64'(exp_ramp));
      if (c == 11) check("b2b_res2", 64'(res), 64'(exp_max));
      tick();
    end
    check("b2b_first_done", 64'(done_c1), 64'd5);
    check("b2b_period", 64'(done_c2 - done_c1), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/polymul_seq.md
Name: polymul_seq

Overview:
Sequencer and accumulator that drives one schoolbook polynomial multiplication on the accelerated multiplier path.
- It captures two operand polynomials presented as bit-planes, the same format the coefficient shift register consumes.
- It streams operand B one coefficient per cycle through an internal coefficient shift register.
- Each step, it accumulates partial products of all A coefficients into a product-coefficient bank.
- It reports completion with a start/busy/done handshake to the surrounding host logic.

Parameters:
- N, 4: coefficients per operand; power of two, at least 2.
- CW, 2: coefficient width; also the number of bit-planes per operand.
- AW, 2*CW+$clog2(N) (=6): accumulator width per product coefficient; derived, not overridden.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a multiplication; sampled each rising edge.
- a_data0, input, N: operand A bit-plane 0. Bit i is the LSB of coefficient a_i.
- a_data1, input, N: operand A bit-plane 1. Bit i is bit 1 of coefficient a_i.
- b_data0, input, N: operand B bit-plane 0, same mapping as A.
- b_data1, input, N: operand B bit-plane 1, same mapping as A.
- busy, output, 1: multiplication in progress.
- done, output, 1: single-cycle completion pulse.
- res_valid, output, 1: res holds a completed product.
- res, output, (2N-1)*AW: product coefficients; c_k is at res[k*AW +: AW].

Behaviour:
- One clock domain. Reset is synchronous and active-high, with ports named clk and reset.
- Reset values:
  - FSM in IDLE.
  - busy=0, done=0, res_valid=0.
  - res=0, step counter=0, operand registers=0.
- Coefficient assembly: a_i = {a_data1[i], a_data0[i]}, and likewise b_i (CW=2). Values are unsigned.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - start=1 is accepted.
  - On acceptance: latch a_0..a_{N-1}, load b into the coefficient shift register, clear all accumulators, counter=0, res_valid=0.
  - Next state is MAC.
- MAC (step k, k=0..N-1):
  - Each cycle, c_{k+j} += a_j*b_k for all j.
  - b_k is taken from the shift register head, then the register shifts by one coefficient.
  - The counter increments each cycle.
  - At k=N-1, next state is DONE.
- DONE:
  - done=1 for exactly this cycle; res_valid is set.
  - Next state is IDLE.
- Timing: start accepted at the end of cycle 0.
  - busy=1 in cycles 1..N.
  - done=1 and busy=0 in cycle N+1.
  - res is final from cycle N+1.
- Result hold: res_valid stays 1 and res stays stable until the next start is accepted.
  - On acceptance, both clear in the following cycle.
- Start is ignored while busy=1 or done=1. Operands are only sampled on acceptance, so input changes during busy have no effect.
- A start held high continuously gives back-to-back operations with a period of N+2 cycles.
- Arithmetic: products are CW x CW to 2CW bits, zero-extended to AW. Overflow is impossible by the AW derivation: maximum c = N*(2^CW-1)^2 = 36 < 64.
- Reset mid-operation:
  - Next cycle matches the reset values (state IDLE, busy=0, res=0).
  - No done pulse is produced for the aborted operation.
- Reset has priority over start in the same cycle.

Decomposition:
- Shared package polymul_pkg holds:
  - default N, CW, AW;
  - the FSM state enum (IDLE/MAC/DONE);
  - a coef_t typedef (CW bits);
  - an acc_t typedef (AW bits).
- One natural sub-module: coef_shift_reg.
  - Ports: load, shift, data0/data1 planes in, head coefficient out.
  - Controlled by the FSM.
- The multiply-accumulate bank stays inline.

Test Plan:
1. Ramp times ones.
   - Stimulus: a_data1=1100, a_data0=1010 (a=0,1,2,3), b_data1=0000, b_data0=1111 (b=1,1,1,1), start one cycle.
   - Required: busy cycles 1-4, done in cycle 5, res c0..c6 = 0,1,3,6,6,5,3, res_valid=1.
2. Maximum values.
   - Stimulus: all planes 1111 (all coefficients 3).
   - Required: c0..c6 = 9,18,27,36,27,18,9, no overflow.
3. Zero operand.
   - Stimulus: b planes = 0000, a arbitrary.
   - Required: all c_k=0, done still pulses in cycle N+1.
4. Start during busy.
   - Stimulus: case 1, then start again with all-3 operands in cycle 2.
   - Required: ignored; result equals case 1; exactly one done pulse.
5. Reset mid-operation.
   - Stimulus: reset=1 in cycle 3 of case 2.
   - Required: next cycle busy=0, res_valid=0, res=0; no done; a subsequent start produces a correct result.
6. Back-to-back.
   - Stimulus: start held high over two operand sets.
   - Required: done pulses 6 cycles apart; each res is correct; res_valid drops for the cycles in between.
